// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared game constants, BCD digit type and converter FSM
//                state encoding, used by the game controller and the score
//                display path.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int          SCORE_W   = 12;
    localparam int          DIGITS    = 3;
    localparam int          LEVEL_W   = 4;
    localparam int unsigned MAX_LEVEL = 9;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic int unsigned max_score(input int unsigned digits);
        int unsigned m;
        m = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_bcd_converter_if.sv
`default_nettype none
// ============================================================================
//  Module      : score_bcd_converter_if
//  Description : Score/level request and BCD display-result bundle between
//                the game controller (master) and the converter (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface score_bcd_converter_if #(
    parameter int SCORE_W = game_pkg::SCORE_W,
    parameter int DIGITS  = game_pkg::DIGITS,
    parameter int LEVEL_W = game_pkg::LEVEL_W
);

    logic                   startOfFrame;
    logic [SCORE_W-1:0]     score;
    logic [LEVEL_W-1:0]     level;
    logic [4*DIGITS-1:0]    score_digits;
    logic [3:0]             level_digit;
    logic                   overflow;
    logic                   busy;
    logic                   digits_valid;

    modport master (
        output startOfFrame, score, level,
        input  score_digits, level_digit, overflow, busy, digits_valid
    );

    modport slave (
        input  startOfFrame, score, level,
        output score_digits, level_digit, overflow, busy, digits_valid
    );

endinterface
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Double-dabble nibble adjust: digits of 5 or more get +3 so
//                that the following left shift carries into the next digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
    import game_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/score_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : score_bcd_converter
//  Description : Per-frame sequential double-dabble conversion of the binary
//                score into BCD digits, with the level clamped to one digit.
//                Score digits, overflow and level update together.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_bcd_converter
    import game_pkg::bcd_digit_t;
#(
    parameter int SCORE_W = game_pkg::SCORE_W,
    parameter int DIGITS  = game_pkg::DIGITS,
    parameter int LEVEL_W = game_pkg::LEVEL_W
) (
    input  wire logic               clk,
    input  wire logic               resetN,   // active-high synchronous reset
    score_bcd_converter_if.slave    bus
);

    // One guard digit above the displayed digits flags out-of-range scores.
    localparam int          c_BCD_W     = 4 * (DIGITS + 1);
    localparam int          c_CNT_W     = $clog2(SCORE_W + 1);
    localparam int unsigned c_MAX_SCORE = game_pkg::max_score(DIGITS);

    localparam logic [1:0]  c_ST_IDLE   = game_pkg::IDLE;
    localparam logic [1:0]  c_ST_SHIFT  = game_pkg::SHIFT;
    localparam logic [1:0]  c_ST_COMMIT = game_pkg::COMMIT;

    logic [1:0]             state_q,        state_d;
    logic [c_CNT_W-1:0]     cnt_q,          cnt_d;
    logic [SCORE_W-1:0]     bin_q,          bin_d;
    logic [SCORE_W-1:0]     score_cap_q,    score_cap_d;
    logic [LEVEL_W-1:0]     level_cap_q,    level_cap_d;
    logic [c_BCD_W-1:0]     bcd_q,          bcd_d;
    logic [4*DIGITS-1:0]    score_digits_q, score_digits_d;
    bcd_digit_t             level_digit_q,  level_digit_d;
    logic                   overflow_q,     overflow_d;

    logic [c_BCD_W-1:0]     w_adj;
    logic [c_BCD_W:0]       w_shift_full;
    logic                   w_guard_nz;
    logic                   w_too_big;
    bcd_digit_t             w_level_clamped;

    generate
        for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (bcd_q[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    // Adjusted accumulator shifted left with the next binary MSB; the extra
    // top bit is whatever falls out of the guard digit.
    assign w_shift_full    = {w_adj, bin_q[SCORE_W-1]};
    assign w_guard_nz      = |w_shift_full[c_BCD_W -: 5];
    assign w_too_big       = 32'(score_cap_q) > c_MAX_SCORE;
    assign w_level_clamped = (32'(level_cap_q) > game_pkg::MAX_LEVEL)
                             ? 4'(game_pkg::MAX_LEVEL) : 4'(level_cap_q);

    // Next-state logic: capture on frame start, shift one bit per cycle, and
    // register the results on the final shift so they are visible for the
    // whole COMMIT cycle alongside the digits_valid pulse.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bin_d          = bin_q;
        score_cap_d    = score_cap_q;
        level_cap_d    = level_cap_q;
        bcd_d          = bcd_q;
        score_digits_d = score_digits_q;
        level_digit_d  = level_digit_q;
        overflow_d     = overflow_q;

        case (state_q)
            c_ST_IDLE: begin
                if (bus.startOfFrame) begin
                    score_cap_d = bus.score;
                    level_cap_d = bus.level;
                    bin_d       = bus.score;
                    bcd_d       = '0;
                    cnt_d       = c_CNT_W'(SCORE_W);
                    state_d     = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                bcd_d = w_shift_full[c_BCD_W-1:0];
                bin_d = {bin_q[SCORE_W-2:0], 1'b0};
                cnt_d = cnt_q - c_CNT_W'(1);
                if (cnt_q == c_CNT_W'(1)) begin
                    state_d = c_ST_COMMIT;
                    if (w_guard_nz || w_too_big) begin
                        score_digits_d = {DIGITS{4'h9}};
                        overflow_d     = 1'b1;
                    end else begin
                        score_digits_d = w_shift_full[4*DIGITS-1:0];
                        overflow_d     = 1'b0;
                    end
                    level_digit_d = w_level_clamped;
                end
            end
            c_ST_COMMIT: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q        <= c_ST_IDLE;
            cnt_q          <= '0;
            bin_q          <= '0;
            score_cap_q    <= '0;
            level_cap_q    <= '0;
            bcd_q          <= '0;
            score_digits_q <= '0;
            level_digit_q  <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bin_q          <= bin_d;
            score_cap_q    <= score_cap_d;
            level_cap_q    <= level_cap_d;
            bcd_q          <= bcd_d;
            score_digits_q <= score_digits_d;
            level_digit_q  <= level_digit_d;
            overflow_q     <= overflow_d;
        end
    end

    assign bus.score_digits = score_digits_q;
    assign bus.level_digit  = level_digit_q;
    assign bus.overflow     = overflow_q;
    assign bus.busy         = (state_q == c_ST_SHIFT);
    assign bus.digits_valid = (state_q == c_ST_COMMIT);

endmodule
`default_nettype wire

// File: doc/score_bcd_converter.md
# score_bcd_converter

Downstream consumer of the game controller's `score` and `level` outputs. It converts the binary score into decimal digits once per frame using a sequential double-dabble (shift-and-add-3) engine, one bit per clock. It holds the digits stable for the VGA number-drawing objects. The level is clamped to a single decimal digit and is updated atomically with the score digits, so the display never shows a half-converted value.

## Interface
Parameters:
- `SCORE_W`, 12: width of the binary score input.
- `DIGITS`, 3: number of BCD score digits produced. The maximum displayable score is 10^DIGITS − 1.
- `LEVEL_W`, 4: width of the level input.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `resetN`  in  1  synchronous, active-high reset. The codebase port name is kept; the reset is asserted when the port = 1.
- `startOfFrame`  in  1  one-cycle pulse per frame (30 Hz) that requests a conversion.
- `score`  in  SCORE_W  binary score from the game controller.
- `level`  in  LEVEL_W  current level from the game controller.
- `score_digits`  out  4*DIGITS  BCD digits; digit 0 (units) is in bits [3:0].
- `level_digit`  out  4  level clamped to 0..9.
- `overflow`  out  1  set when the last converted score exceeded 10^DIGITS − 1.
- `busy`  out  1  high while a conversion is in progress.
- `digits_valid`  out  1  one-cycle pulse when the outputs update.

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE: when `startOfFrame`=1, capture `score` and `level` into internal registers, clear the BCD accumulator, load the shift register, set the bit counter to SCORE_W, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT: each cycle does the following:
  - Add 3 to every BCD nibble that is ≥ 5.
  - Shift {BCD, binary} left by one bit.
  - Decrement the counter.
  - When the counter reaches 1 in this cycle (final shift), go to COMMIT.
- BCD accumulator width: 4*(DIGITS+1) internally. The extra guard digit detects overflow.
- COMMIT:
  - If the guard digit is ≠ 0, or the captured score is > 10^DIGITS − 1, drive `score_digits` to all 9s and set `overflow`=1.
  - Otherwise drive the converted digits and set `overflow`=0.
  - `level_digit` = min(captured level, 9).
  - Pulse `digits_valid` and return to IDLE.
- `startOfFrame` pulses in SHIFT or COMMIT are ignored; they are not queued.
- `score` and `level` changes after capture do not affect the conversion in progress.
- Outputs hold their values between commits.

## Timing
- Reset values: `score_digits`=0, `level_digit`=0, `overflow`=0, `busy`=0, `digits_valid`=0, state=IDLE, internal registers=0.
- A reset during SHIFT or COMMIT aborts the conversion; no commit occurs, and outputs read 0 on the cycle after reset.
- Pulse sampled at edge T: `busy` goes to 1 from T+1.
- SHIFT occupies T+1..T+SCORE_W.
- COMMIT at T+SCORE_W+1: new outputs and the `digits_valid` pulse are visible from T+SCORE_W+1 to T+SCORE_W+2; `busy` drops at the same edge.
- Total latency is SCORE_W+1 cycles from the pulse to the new outputs. This is far shorter than the frame period, so no frame is ever skipped in normal use.
- Simultaneous `resetN` and `startOfFrame`: reset wins.

## Structure
- Shared package `game_pkg` holds:
  - `SCORE_W`, `DIGITS`, `MAX_LEVEL`
  - `typedef logic [3:0] bcd_digit_t`
  - the FSM enum `conv_state_t` {IDLE, SHIFT, COMMIT}
- The game controller imports the same `SCORE_W`/`MAX_LEVEL` from the package.
- Sub-module `bcd_add3`: combinational nibble adjust (≥5 → +3), instantiated DIGITS+1 times in a generate loop.

## Test plan
- Reset, then score=275, level=2, one `startOfFrame` → after 13 cycles `score_digits`=0x275, `level_digit`=2, `overflow`=0, one `digits_valid` pulse, `busy` high exactly 12 cycles.
- score=0 → `score_digits`=0x000. Then score=999 → 0x999, `overflow`=0.
- score=1000 and score=4095 → `score_digits`=0x999, `overflow`=1 for each. A following score=5 clears `overflow` to 0.
- score=275 converts; score changes to 300 and a second `startOfFrame` arrive 4 cycles into SHIFT → result 0x275, a single `digits_valid`; the next frame yields 0x300.
- `resetN`=1 for one cycle mid-SHIFT (cycle 6) → no `digits_valid`, outputs 0, `busy`=0. The next pulse converts normally.
- level=12 → `level_digit`=9. level=5 → 5, updated in the same cycle as `score_digits`.
